// File: rtl/pong_sound_pkg.sv
// Shared Pong sound codes: channel/sound request encodings and the player FSM states.
package pong_sound_pkg;

  typedef enum logic [1:0] {NONE = 2'd0, RIGHT = 2'd1, LEFT = 2'd2, BOTH = 2'd3} channel_e;
  typedef enum logic [1:0] {SILENT = 2'd0, PING = 2'd1, PONG = 2'd2, GOAL = 2'd3} sound_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1, ST_HOLD = 2'd2} state_e;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Square-wave divider: counts 0..half-1 and toggles phase at each wrap.
module tone_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         run,
  input  logic         start,
  input  logic         clr,
  input  logic [W-1:0] half,
  output logic         phase_nxt
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         phase_q, phase_d;

  // Stopping wins over everything so a wrap on the way to idle is dropped.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (!run) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (start) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (clr) begin
      cnt_d = '0;
    end else if (cnt_q == half - 1'b1) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase_nxt = phase_d;

endmodule

// File: rtl/sound_player.sv
// Pong sound player: syncs the (channel, sound) request and drives L/R square waves.
// Define SOUND_WARBLE_EN to make the goal tone alternate between GOAL_HZ and GOAL2_HZ.
module sound_player
  import pong_sound_pkg::*;
#(
  parameter int CLK_HZ    = 25_000_000,
  parameter int PING_HZ   = 1000,
  parameter int PONG_HZ   = 500,
  parameter int GOAL_HZ   = 250,
  parameter int GOAL2_HZ  = 375,
  parameter int WARBLE_MS = 50,
  parameter int MIN_MS    = 20
) (
  input  logic       snd_clk,
  input  logic       reset_n,
  input  logic [1:0] channel,
  input  logic [1:0] sound,
  output logic       audio_l,
  output logic       audio_r,
  output logic       busy
);

  localparam int HALF_PING  = CLK_HZ / (2 * PING_HZ);
  localparam int HALF_PONG  = CLK_HZ / (2 * PONG_HZ);
  localparam int HALF_GOAL  = CLK_HZ / (2 * GOAL_HZ);
  localparam int HALF_GOAL2 = CLK_HZ / (2 * GOAL2_HZ);
  localparam int HALF_MAX   = max_int(max_int(HALF_PING, HALF_PONG), max_int(HALF_GOAL, HALF_GOAL2));
  localparam int CW         = $clog2(HALF_MAX + 1);
  localparam int MS_DIV     = CLK_HZ / 1000;
  localparam int PW         = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam int MW         = $clog2(MIN_MS + 1);

  if (HALF_PING < 2 || HALF_PONG < 2 || HALF_GOAL < 2 || HALF_GOAL2 < 2 ||
      MIN_MS < 1 || WARBLE_MS < 1) begin : g_bad_params
    $error("sound_player: tone half-period below 2 cycles or zero ms setting");
  end

  logic [1:0]    ch_s1_q, ch_s2_q, snd_s1_q, snd_s2_q;
  logic [PW-1:0] ms_cnt_q, ms_cnt_d;
  logic          ms_tick;
  state_e        state_q, state_d;
  logic [1:0]    cur_ch_q, cur_ch_d, cur_snd_q, cur_snd_d;
  logic [MW-1:0] min_q, min_d;
  logic          req, start, run, wb_swap, phase_d;
  logic [CW-1:0] half, half_goal;
  logic          audio_l_q, audio_r_q, busy_q;

  assign ms_tick  = (ms_cnt_q == PW'(MS_DIV - 1));
  assign ms_cnt_d = ms_tick ? '0 : ms_cnt_q + 1'b1;
  assign req      = (ch_s2_q != NONE) && (snd_s2_q != SILENT);

  always_comb begin
    state_d   = state_q;
    cur_ch_d  = cur_ch_q;
    cur_snd_d = cur_snd_q;
    start     = 1'b0;
    min_d     = (ms_tick && min_q != '0) ? min_q - 1'b1 : min_q;
    case (state_q)
      ST_IDLE: if (req) begin
        start   = 1'b1;
        state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (ch_s2_q == NONE)
          state_d = (min_q == '0) ? ST_IDLE : ST_HOLD;
        else if (req && {ch_s2_q, snd_s2_q} != {cur_ch_q, cur_snd_q})
          start = 1'b1;
      end
      ST_HOLD: begin
        if (req) begin
          start   = 1'b1;
          state_d = ST_PLAY;
        end else if (min_q == '0) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (start) begin
      cur_ch_d  = ch_s2_q;
      cur_snd_d = snd_s2_q;
      min_d     = MW'(MIN_MS);
    end
  end

  assign run = (state_d != ST_IDLE);

`ifdef SOUND_WARBLE_EN
  localparam int WW = $clog2(WARBLE_MS + 1);
  logic [WW-1:0] wb_cnt_q, wb_cnt_d;
  logic          wb_sel_q, wb_sel_d;

  always_comb begin
    wb_cnt_d = wb_cnt_q;
    wb_sel_d = wb_sel_q;
    wb_swap  = 1'b0;
    if (start) begin
      wb_cnt_d = '0;
      wb_sel_d = 1'b0;
    end else if (state_q != ST_IDLE && cur_snd_q == GOAL && ms_tick) begin
      if (wb_cnt_q == WW'(WARBLE_MS - 1)) begin
        wb_cnt_d = '0;
        wb_sel_d = ~wb_sel_q;
        wb_swap  = 1'b1;
      end else begin
        wb_cnt_d = wb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge snd_clk or negedge reset_n) begin
    if (!reset_n) begin
      wb_cnt_q <= '0;
      wb_sel_q <= 1'b0;
    end else begin
      wb_cnt_q <= wb_cnt_d;
      wb_sel_q <= wb_sel_d;
    end
  end

  assign half_goal = wb_sel_q ? CW'(HALF_GOAL2) : CW'(HALF_GOAL);
`else
  assign wb_swap   = 1'b0;
  assign half_goal = CW'(HALF_GOAL);
`endif

  always_comb begin
    case (cur_snd_q)
      PONG:    half = CW'(HALF_PONG);
      GOAL:    half = half_goal;
      default: half = CW'(HALF_PING);
    endcase
  end

  tone_divider #(.W(CW)) u_tone (
    .clk       (snd_clk),
    .rst_n     (reset_n),
    .run       (run),
    .start     (start),
    .clr       (wb_swap),
    .half      (half),
    .phase_nxt (phase_d)
  );

  // Outputs register next-state values so audio lands on the same edge as the FSM.
  always_ff @(posedge snd_clk or negedge reset_n) begin
    if (!reset_n) begin
      ch_s1_q   <= '0;
      ch_s2_q   <= '0;
      snd_s1_q  <= '0;
      snd_s2_q  <= '0;
      ms_cnt_q  <= '0;
      state_q   <= ST_IDLE;
      cur_ch_q  <= '0;
      cur_snd_q <= '0;
      min_q     <= '0;
      audio_l_q <= 1'b0;
      audio_r_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ch_s1_q   <= channel;
      ch_s2_q   <= ch_s1_q;
      snd_s1_q  <= sound;
      snd_s2_q  <= snd_s1_q;
      ms_cnt_q  <= ms_cnt_d;
      state_q   <= state_d;
      cur_ch_q  <= cur_ch_d;
      cur_snd_q <= cur_snd_d;
      min_q     <= min_d;
      audio_l_q <= phase_d & cur_ch_d[1];
      audio_r_q <= phase_d & cur_ch_d[0];
      busy_q    <= run;
    end
  end

  assign audio_l = audio_l_q;
  assign audio_r = audio_r_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_sound_player.sv
// Randomized bench for sound_player (default build: steady goal tone).
module tb_sound_player;

  localparam int MAXC = 3000;

  logic       snd_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [1:0] channel = 2'd0;
  logic [1:0] sound   = 2'd0;
  logic       audio_l, audio_r, busy;

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] obs [1:MAXC];

  always #5 snd_clk = ~snd_clk;

  sound_player #(.CLK_HZ(100_000), .MIN_MS(2), .WARBLE_MS(1)) dut (
    .snd_clk (snd_clk),
    .reset_n (reset_n),
    .channel (channel),
    .sound   (sound),
    .audio_l (audio_l),
    .audio_r (audio_r),
    .busy    (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int half_of(input logic [1:0] s);
    case (s)
      2'd1:    return 50;
      2'd2:    return 100;
      2'd3:    return 200;
      default: return 1;
    endcase
  endfunction

  // Expected {busy, audio_l, audio_r} j cycles in, for a tone that started at cycle s.
  function automatic logic [2:0] tone_at(input int j, input int s, input logic [1:0] c,
                                         input logic [1:0] snd);
    bit ph;
    ph = (((j - s) / half_of(snd)) % 2) == 0;
    return {1'b1, ph & c[1], ph & c[0]};
  endfunction

  // Request (c1,s1) for l1 cycles, then optionally (c2,s2) for l2 cycles, then drop.
  task automatic play(input logic [1:0] c1, input logic [1:0] s1, input int l1,
                      input logic [1:0] c2, input logic [1:0] s2, input int l2,
                      input string tag);
    int hold_end, total, e;
    bit active, retrig;
    logic [2:0] exp;
    hold_end = l1 + l2;
    total    = hold_end + 260;
    active   = (c1 != 0) && (s1 != 0);
    retrig   = (l2 > 0) && ({c2, s2} != {c1, s1});
    @(posedge snd_clk); #1;
    channel = c1; sound = s1;
    for (int j = 1; j <= total; j++) begin
      @(posedge snd_clk); #1;
      if (l2 > 0 && j == l1) begin channel = c2; sound = s2; end
      if (j == hold_end) begin channel = 2'd0; sound = 2'd0; end
      @(negedge snd_clk);
      obs[j] = {busy, audio_l, audio_r};
    end
    if (!active) begin
      e = 3;
    end else if (hold_end >= 201) begin
      e = hold_end + 3;
    end else begin
      // Short request: HOLD stretches it to the 2nd ms tick after start (+1 edge).
      e = total + 1;
      for (int j = total; j >= 4; j--) if (obs[j][2] == 1'b0 && obs[j-1][2] == 1'b1) e = j;
      chk({tag, "_end_win"}, 32'(e >= 105 && e <= 204), 32'd1);
    end
    for (int j = 1; j <= total; j++) begin
      if (j < 3 || j >= e)               exp = 3'b000;
      else if (retrig && j >= l1 + 3)    exp = tone_at(j, l1 + 3, c2, s2);
      else                               exp = tone_at(j, 3, c1, s1);
      chk($sformatf("%s@%0d", tag, j), 32'(obs[j]), 32'(exp));
    end
  endtask

  task automatic reset_mid();
    int guard;
    @(posedge snd_clk); #1;
    channel = 2'd3; sound = 2'd1;
    repeat (30) @(posedge snd_clk);
    #1 chk("rst_pre", 32'({busy, audio_l, audio_r}), 32'd7);
    #2 reset_n = 1'b0;
    #1 chk("rst_async", 32'({busy, audio_l, audio_r}), 32'd0);
    @(posedge snd_clk); #2 reset_n = 1'b1;
    for (int j = 1; j <= 60; j++) begin
      @(posedge snd_clk); @(negedge snd_clk);
      chk($sformatf("rst_restart@%0d", j), 32'({busy, audio_l, audio_r}),
          (j < 3) ? 32'd0 : ((((j - 3) / 50) % 2 == 0) ? 32'd7 : 32'd4));
    end
    channel = 2'd0; sound = 2'd0;
    guard = 0;
    while (busy && guard < 400) begin @(negedge snd_clk); guard++; end
    chk("rst_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] c1, s1, c2, s2;
    int mode, l1, l2;
    repeat (3) @(negedge snd_clk);
    chk("reset_state", 32'({busy, audio_l, audio_r}), 32'd0);
    @(posedge snd_clk); #2 reset_n = 1'b1;

    play(2'd3, 2'd1, 1000, 2'd0, 2'd0, 0, "ping_both");
    play(2'd2, 2'd2, 10,   2'd0, 2'd0, 0, "pong_pulse");
    play(2'd3, 2'd1, 300,  2'd1, 2'd2, 400, "retrig");
    play(2'd1, 2'd3, 700,  2'd0, 2'd0, 0, "goal");
    play(2'd3, 2'd0, 300,  2'd0, 2'd0, 0, "no_sound");
    reset_mid();

    for (int k = 0; k < 10; k++) begin
      c1   = 2'($urandom_range(1, 3));
      s1   = 2'($urandom_range(1, 3));
      mode = $urandom_range(0, 2);
      c2 = 2'd0; s2 = 2'd0; l2 = 0;
      if (mode == 0) l1 = $urandom_range(5, 90);
      else if (mode == 1) l1 = $urandom_range(210, 500);
      else begin
        l1 = $urandom_range(20, 300);
        l2 = $urandom_range(210, 400);
        do begin
          c2 = 2'($urandom_range(1, 3));
          s2 = 2'($urandom_range(1, 3));
        end while ({c2, s2} == {c1, s1});
      end
      play(c1, s1, l1, c2, s2, l2, $sformatf("rnd%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
